// File: rtl/uart_transmitter_if.sv
// Host-side handshake and serial line of the UART transmitter.
// master = host issuing bytes, slave = transmitter.
interface uart_transmitter_if;
    logic       txEn;
    logic       txStart;
    logic [7:0] tx_data;
    logic       tx;
    logic       ready;
    logic       busy;
    logic       done;

    modport master (
        output txEn, txStart, tx_data,
        input  tx, ready, busy, done
    );

    modport slave (
        input  txEn, txStart, tx_data,
        output tx, ready, busy, done
    );
endinterface

// File: rtl/uart_transmitter.sv
// UART framer: start, 8 data LSB-first, optional even parity, stop; tx low 1 cycle after accept.
// No queuing: txStart is taken only when ready (IDLE, enabled, out of reset), otherwise dropped.
module uart_transmitter #(
    parameter int TICKS_PER_BIT = 16,
    parameter bit PARITY_EN     = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    uart_transmitter_if.slave bus
);
    localparam int TW = (TICKS_PER_BIT > 16) ? $clog2(TICKS_PER_BIT) : 4;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA_BITS = 3'd2,
        PARITY    = 3'd3,
        STOP_BIT  = 3'd4
    } state_t;

    state_t          state_q;
    logic [TW-1:0]   tick_q;
    logic [2:0]      idx_q;
    logic [7:0]      shift_q;
    logic            par_q;
    logic            tx_q;
    logic            busy_q;
    logic            done_q;
    logic            tick_last;

    assign tick_last = (tick_q == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (!bus.txEn) begin
            state_q <= IDLE;
            tick_q  <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tick_q <= '0;
                    idx_q  <= '0;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (bus.txStart) begin
                        shift_q <= bus.tx_data;
                        par_q   <= ^bus.tx_data;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= START_BIT;
                    end
                end
                START_BIT: begin
                    if (tick_last) begin
                        tick_q  <= '0;
                        idx_q   <= '0;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                        state_q <= DATA_BITS;
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                DATA_BITS: begin
                    if (tick_last) begin
                        tick_q <= '0;
                        if (idx_q == 3'd7) begin
                            // Parity was computed at capture, so the emptied shifter is irrelevant here.
                            if (PARITY_EN) begin
                                tx_q    <= par_q;
                                state_q <= PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= STOP_BIT;
                            end
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                PARITY: begin
                    if (tick_last) begin
                        tick_q  <= '0;
                        tx_q    <= 1'b1;
                        state_q <= STOP_BIT;
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                STOP_BIT: begin
                    if (tick_last) begin
                        tick_q  <= '0;
                        idx_q   <= '0;
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tick_q  <= '0;
                    idx_q   <= '0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx    = tx_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.ready = (state_q == IDLE) && bus.txEn && !rst;
endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: parity build (dut0) and no-parity build (dut1) share clk/rst;
// a negedge monitor deserialises tx and scores each completed frame against a queue.
module tb_uart_transmitter;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_transmitter_if if0 ();
    uart_transmitter_if if1 ();

    uart_transmitter #(.TICKS_PER_BIT(T), .PARITY_EN(1'b1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    uart_transmitter #(.TICKS_PER_BIT(T), .PARITY_EN(1'b0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    typedef struct {
        logic [10:0] frame;
        int          nbits;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor state, one slot per DUT
    logic        mon_in        [2] = '{1'b0, 1'b0};
    int          mon_cnt       [2] = '{0, 0};
    logic [10:0] mon_bits      [2] = '{11'd0, 11'd0};
    logic        mon_prev_done [2] = '{1'b0, 1'b0};

    task automatic mon_step(input int id, input logic busy, input logic done, input logic tx);
        exp_t e;
        logic perr;
        int   k;
        if (mon_prev_done[id] === 1'b1) check("done_one_cycle", done, 0);
        if (done === 1'b1) begin
            if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
                check("unexpected_done", done, 0);
            end else begin
                if (id == 0) e = exp_q0.pop_front();
                else         e = exp_q1.pop_front();
                check("frame_len", mon_cnt[id], e.nbits * T);
                check("frame_bits", mon_bits[id], e.frame);
                if (e.nbits == 11) begin
                    perr = mon_bits[id][9] ^ (^mon_bits[id][8:1]);
                    check("parity_err", perr, 0);
                end
            end
            mon_in[id] = 1'b0;
        end else if (busy === 1'b1) begin
            if (!mon_in[id]) begin
                mon_in[id]   = 1'b1;
                mon_cnt[id]  = 0;
                mon_bits[id] = '0;
            end
            k = mon_cnt[id] / T;
            if ((mon_cnt[id] % T) == T / 2 && k < 11) mon_bits[id][k] = tx;
            mon_cnt[id]++;
        end else begin
            mon_in[id] = 1'b0;
        end
        mon_prev_done[id] = done;
    endtask

    always @(negedge clk) begin
        mon_step(0, if0.busy, if0.done, if0.tx);
        mon_step(1, if1.busy, if1.done, if1.tx);
    end

    function automatic logic rdy(input int id);
        return (id == 0) ? if0.ready : if1.ready;
    endfunction

    function automatic logic dn(input int id);
        return (id == 0) ? if0.done : if1.done;
    endfunction

    task automatic wait_ready(input int id);
        for (int i = 0; i < 400 && rdy(id) !== 1'b1; i++) @(negedge clk);
        check("wait_ready", rdy(id), 1);
    endtask

    task automatic wait_done(input int id);
        for (int i = 0; i < 400 && dn(id) !== 1'b1; i++) @(negedge clk);
        check("wait_done", dn(id), 1);
    endtask

    // Issue one byte; par is the hand-computed even parity, push=0 for frames expected to be cut short.
    task automatic send(input int id, input logic [7:0] d, input bit push, input logic par);
        exp_t e;
        wait_ready(id);
        if (push) begin
            if (id == 0) begin
                e.frame = {1'b1, par, d, 1'b0};
                e.nbits = 11;
                exp_q0.push_back(e);
            end else begin
                e.frame = {1'b0, 1'b1, d, 1'b0};
                e.nbits = 10;
                exp_q1.push_back(e);
            end
        end
        if (id == 0) begin
            if0.tx_data = d; if0.txStart = 1'b1;
        end else begin
            if1.tx_data = d; if1.txStart = 1'b1;
        end
        @(negedge clk);
        if (id == 0) begin
            if0.txStart = 1'b0; if0.tx_data = ~d;
            check("start_latency_tx", if0.tx, 0);
            check("start_latency_busy", if0.busy, 1);
        end else begin
            if1.txStart = 1'b0; if1.tx_data = ~d;
            check("start_latency_tx", if1.tx, 0);
            check("start_latency_busy", if1.busy, 1);
        end
    endtask

    initial begin
        rst = 1'b1;
        if0.txEn = 1'b1; if0.txStart = 1'b0; if0.tx_data = 8'h00;
        if1.txEn = 1'b1; if1.txStart = 1'b0; if1.tx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ready", if0.ready, 0);
        check("rst_tx", if0.tx, 1);
        check("rst_busy", if0.busy, 0);
        check("rst_done", if0.done, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", if0.ready, 1);

        send(0, 8'hA5, 1, 1'b0);
        wait_done(0);
        send(0, 8'h07, 1, 1'b1);
        wait_done(0);

        // Back-to-back: second request issued in the done cycle
        send(0, 8'h3C, 1, 1'b0);
        wait_done(0);
        send(0, 8'hFF, 1, 1'b0);
        wait_done(0);

        // Request while busy must be dropped
        send(0, 8'hA5, 1, 1'b0);
        repeat (40) @(negedge clk);
        check("busy_not_ready", if0.ready, 0);
        if0.tx_data = 8'h55; if0.txStart = 1'b1;
        @(negedge clk);
        if0.txStart = 1'b0;
        wait_done(0);
        repeat (5) @(negedge clk);
        check("ignored_no_restart", if0.busy, 0);

        // Enable dropped during data bit 4
        send(0, 8'hA5, 0, 1'b0);
        repeat (85) @(negedge clk);
        check("pre_abort_busy", if0.busy, 1);
        if0.txEn = 1'b0;
        @(negedge clk);
        check("abort_tx", if0.tx, 1);
        check("abort_busy", if0.busy, 0);
        check("abort_done", if0.done, 0);
        if0.txEn = 1'b1;
        repeat (3) @(negedge clk);
        send(0, 8'h81, 1, 1'b0);
        wait_done(0);

        // Reset during the parity bit of 0x5A (parity 0)
        send(0, 8'h5A, 0, 1'b0);
        repeat (150) @(negedge clk);
        check("parity_phase_busy", if0.busy, 1);
        check("parity_bit_5A", if0.tx, 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx", if0.tx, 1);
        check("midrst_busy", if0.busy, 0);
        check("midrst_done", if0.done, 0);
        check("midrst_ready", if0.ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_release_ready", if0.ready, 1);

        // No-parity build
        send(1, 8'hA5, 1, 1'b0);
        wait_done(1);

        repeat (5) @(negedge clk);
        check("exp_q0_drained", exp_q0.size(), 0);
        check("exp_q1_drained", exp_q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
